// File: rtl/modular_square_ggg_iter_ctrl.sv
// -----------------------------------------------------------------------------
// modular_square_ggg_iter_ctrl
//
// Iteration sequencer for the GGG modular-squaring loop. Loads the seed once
// (load_sq_in + ce), then raises ce once every PIPE_DEPTH cycles so the final
// stage captures each new accumulator sum. It counts completed squarings
// against the N captured at start, and holds done until result_ack.
// Control only: no data word passes through this block.
//
// Optional feature macro: MODSQ_ITER_CTRL_CKPT_EN
//   When defined, a CKPT_LOG2-bit counter advances on every RUN ce. Each wrap
//   to 0 produces a one-cycle ckpt_valid pulse, aligned with the iter_count
//   update. When undefined, ckpt_valid is constant 0.
//
// Parameters
//   PIPE_DEPTH    cycles per squaring (>= 1)
//   ITER_CNT_LEN  width of the iteration counters
//   CKPT_LOG2     checkpoint interval is 2**CKPT_LOG2 iterations (>= 1)
//
// Ports
//   clk         clock
//   rst_n       asynchronous active-low reset
//   start       request a run (sampled only in IDLE)
//   num_iter    number of squarings, captured when start is accepted
//   abort       synchronous cancel from any state
//   result_ack  consumer acknowledges done
//   load_sq_in  registered; selects the seed path in the final stage
//   ce          registered; capture enable for the final stage
//   busy        registered; high in LOAD and RUN
//   done        registered; high in DONE
//   iter_count  registered; squarings completed in the current run
//   ckpt_valid  registered; one-cycle checkpoint pulse
// -----------------------------------------------------------------------------
module modular_square_ggg_iter_ctrl #(
   parameter int PIPE_DEPTH   = 8,
   parameter int ITER_CNT_LEN = 64,
   parameter int CKPT_LOG2    = 20
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic [ITER_CNT_LEN-1:0] num_iter,
   input  logic                    abort,
   input  logic                    result_ack,
   output logic                    load_sq_in,
   output logic                    ce,
   output logic                    busy,
   output logic                    done,
   output logic [ITER_CNT_LEN-1:0] iter_count,
   output logic                    ckpt_valid
);

   localparam int PH_W = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;
   localparam logic [PH_W-1:0] PH_LAST = PH_W'(PIPE_DEPTH - 1);

   if (PIPE_DEPTH < 1 || CKPT_LOG2 < 1) begin : g_bad_param
      $error("modular_square_ggg_iter_ctrl: PIPE_DEPTH and CKPT_LOG2 must be >= 1");
   end

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_RUN,
      S_DONE
   } state_e;

   state_e                  state_q, state_d;
   logic [PH_W-1:0]         phase_q, phase_d;
   logic [ITER_CNT_LEN-1:0] n_q, n_d;
   logic [ITER_CNT_LEN-1:0] iter_q, iter_d;
   logic [ITER_CNT_LEN-1:0] iter_inc;
   logic                    load_q, load_d;
   logic                    ce_q, ce_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;
   logic                    run_wrap;   // RUN cycle in which the stage captures

   // iter_q never exceeds n_q, so the increment cannot overflow even when
   // N = 2**ITER_CNT_LEN - 1.
   assign iter_inc = iter_q + 1'b1;
   assign run_wrap = (state_q == S_RUN) && (phase_q == PH_LAST);

   // State and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         phase_q <= '0;
         n_q     <= '0;
         iter_q  <= '0;
         load_q  <= 1'b0;
         ce_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments keep every flop sampling the
         // pre-edge values, independent of statement order.
         state_q <= state_d;
         phase_q <= phase_d;
         n_q     <= n_d;
         iter_q  <= iter_d;
         load_q  <= load_d;
         ce_q    <= ce_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // Next-state logic
   always_comb begin
      // NOTE: defaults first so every path assigns every signal; otherwise
      // synthesis infers latches.
      state_d = state_q;
      phase_d = phase_q;
      n_d     = n_q;
      iter_d  = iter_q;
      if (abort) begin
         state_d = S_IDLE;
         phase_d = '0;
         iter_d  = '0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (start) begin
                  n_d     = num_iter;
                  iter_d  = '0;
                  phase_d = '0;
                  state_d = S_LOAD;
               end
            end
            S_LOAD: state_d = (n_q == '0) ? S_DONE : S_RUN;
            S_RUN: begin
               if (phase_q == PH_LAST) begin
                  phase_d = '0;
                  iter_d  = iter_inc;
                  if (iter_inc == n_q) state_d = S_DONE;
               end else begin
                  phase_d = phase_q + 1'b1;
               end
            end
            S_DONE: if (result_ack) state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Outputs are decoded from the next state so they appear registered in the
   // same cycle the state register enters that state.
   always_comb begin
      load_d = (state_d == S_LOAD);
      ce_d   = load_d || ((state_d == S_RUN) && (phase_d == PH_LAST));
      busy_d = (state_d == S_LOAD) || (state_d == S_RUN);
      done_d = (state_d == S_DONE);
   end

`ifdef MODSQ_ITER_CTRL_CKPT_EN
   logic [CKPT_LOG2-1:0] ckpt_q, ckpt_d;
   logic                 ckpt_valid_q, ckpt_valid_d;

   // Advances on each RUN capture; the pulse lands with the iter_count update.
   always_comb begin
      ckpt_d       = ckpt_q;
      ckpt_valid_d = 1'b0;
      if (abort || (state_q == S_IDLE && start)) begin
         ckpt_d = '0;
      end else if (run_wrap) begin
         ckpt_d       = ckpt_q + 1'b1;
         ckpt_valid_d = &ckpt_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ckpt_q       <= '0;
         ckpt_valid_q <= 1'b0;
      end else begin
         ckpt_q       <= ckpt_d;
         ckpt_valid_q <= ckpt_valid_d;
      end
   end

   assign ckpt_valid = ckpt_valid_q;
`else
   logic unused_run_wrap;
   assign unused_run_wrap = run_wrap;
   assign ckpt_valid      = 1'b0;
`endif

   assign load_sq_in = load_q;
   assign ce         = ce_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign iter_count = iter_q;

endmodule

// File: doc/modular_square_ggg_iter_ctrl.md
# modular_square_ggg_iter_ctrl

Iteration sequencer for the GGG modular-squaring loop. Drives the `load_sq_in` and `ce` controls of the final mux/add/register stage. It loads the seed once, then enables one capture per squaring after a fixed pipeline depth, and counts completed squarings against a requested total. It also reports completion through a hold-until-acknowledged done handshake. It contains control logic only and does not touch any data word.

## Interface
- `PIPE_DEPTH`, 8: cycles per squaring, from a stage capture to the next valid accumulator sum; legal range ≥1.
- `ITER_CNT_LEN`, 64: width of iteration counters.
- `CKPT_LOG2`, 20: checkpoint interval is 2^CKPT_LOG2 iterations; used only with the macro.
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: request a run; sampled only in IDLE.
- `num_iter` in ITER_CNT_LEN: number of squarings; captured on accepted `start`.
- `abort` in 1: synchronous cancel from any state.
- `result_ack` in 1: consumer acknowledges `done`.
- `load_sq_in` out 1: registered; selects the seed path in the final stage.
- `ce` out 1: registered; capture enable for the final stage.
- `busy` out 1: registered; high in LOAD and RUN.
- `done` out 1: registered; high in DONE.
- `iter_count` out ITER_CNT_LEN: registered; squarings completed in the current run.
- `ckpt_valid` out 1: registered one-cycle checkpoint pulse; tied 0 without the macro.

## Operation
- States: IDLE, LOAD, RUN, DONE. Encoding is free.
- IDLE:
  - `start`=1 → capture `num_iter`, clear `iter_count` and phase, go to LOAD.
  - `start` in any other state is ignored.
- LOAD lasts exactly one cycle:
  - `load_sq_in`=1 and `ce`=1.
  - Next state is DONE if the captured N=0, otherwise RUN.
- RUN:
  - Phase counter counts 0..PIPE_DEPTH-1 and wraps to 0.
  - At phase PIPE_DEPTH-1: `ce`=1, `load_sq_in`=0, `iter_count`+1.
  - If the incremented count equals N, the next state is DONE.
  - `ce`=0 at all other phases.
- DONE:
  - `done`=1, `ce`=0, and `iter_count` is held.
  - `result_ack`=1 → IDLE.
  - `start` is ignored until IDLE is reached.
- `abort`=1:
  - Next state is IDLE, and all outputs are 0 the following cycle.
  - `iter_count` is cleared.
  - Abort has priority over `start`, `result_ack`, and the phase wrap.
- Arithmetic:
  - `iter_count` compares against the captured N, never the live `num_iter` input.
  - N=2^ITER_CNT_LEN-1 completes without counter overflow.
- `load_sq_in` is never 1 without `ce`=1.
- Reset values: every output 0, state IDLE, all counters 0.

## Timing
- `start` is sampled high in cycle 0:
  - Cycle 1: LOAD.
  - Cycles 1+k·PIPE_DEPTH for k=1..N: `ce` pulses.
  - Cycle 2+N·PIPE_DEPTH: `done` rises.
- `iter_count` shows the value k in the cycle after the k-th RUN `ce`.
- PIPE_DEPTH=1: `ce` is high in every RUN cycle.
- `result_ack` in the same cycle `done` first rises is honoured: IDLE next cycle.
- A new `start` is accepted at the earliest in the cycle after returning to IDLE.
- Reset asserted mid-run: outputs go to 0 immediately (asynchronous), and nothing resumes after release.

## Configuration
- Macro: `MODSQ_ITER_CTRL_CKPT_EN`.
- Defined: a free-running checkpoint counter of CKPT_LOG2 bits advances on each RUN `ce`.
  - On wrap to 0, `ckpt_valid` pulses for one cycle, aligned with the `iter_count` update.
  - The counter clears on `start` and on `abort`.
- Undefined: no checkpoint counter, and `ckpt_valid` is constant 0.

## Test plan
- PIPE_DEPTH=8, N=3, `start` in cycle 0 → `load_sq_in`+`ce` in cycle 1, `ce` in cycles 9/17/25, `done` in cycle 26, `iter_count`=3.
- N=0 → LOAD in cycle 1, `done` in cycle 2, no RUN `ce`, `iter_count`=0.
- PIPE_DEPTH=1, N=5 → `ce` continuously in cycles 1–6, `done` in cycle 7; pulse `start` in cycle 3 → ignored, with no change to N or timing.
- `abort` in cycle 12 of an N=10, PIPE_DEPTH=8 run → cycle 13 has all outputs 0 and IDLE; restart with N=1 → normal sequence.
- `rst_n` low in cycle 10 mid-RUN → outputs 0 the same cycle, IDLE after release; `done` held for 5 cycles without `result_ack`, then ack → IDLE next cycle.
- Macro on, CKPT_LOG2=2, N=9, PIPE_DEPTH=2 → `ckpt_valid` aligned with `iter_count` becoming 4 and 8; macro off → `ckpt_valid` never 1.
